// File: rtl/nios_upc_mem_fill_check.sv
// nios_upc_mem_fill_check
// Avalon-MM master for the on-chip RAM s2 port. Under CSR control it fills a
// word range with a fixed or incrementing pattern, or reads the range back
// and counts mismatches against the same pattern. Raises a level IRQ on done.
module nios_upc_mem_fill_check #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        csr_address,
    input  logic              csr_chipselect,
    input  logic              csr_write,
    input  logic              csr_read,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic              irq,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RD,
        S_CMP_LAST,
        S_FIN
    } state_t;

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_W;

    state_t            r_state;
    logic              r_mode;
    logic              r_inc;
    logic              r_irq_en;
    logic              r_done;
    logic              r_err;
    logic              r_aborted;
    logic              r_abort_pend;
    logic [ADDR_W-1:0] r_start_addr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_pattern;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_left;
    logic              r_cmp_vld;
    logic [ADDR_W-1:0] r_cmp_addr;
    logic [DATA_W-1:0] r_cmp_exp;
    logic [CNT_W-1:0]  r_mis_cnt;
    logic [ADDR_W-1:0] r_first_bad;
    logic              r_first_valid;
    logic [31:0]       r_rdata;

    logic              w_wr;
    logic              w_wr_ctrl;
    logic              w_start;
    logic              w_abort;
    logic              w_done_clr;
    logic              w_busy;
    logic              w_active;
    logic              w_cmp_en;
    logic              w_mismatch;
    logic [CNT_W-1:0]  w_range_cnt;
    logic [CNT_W-1:0]  w_cnt_clamp;
    logic              w_unused;

    assign w_wr        = csr_chipselect & csr_write;
    assign w_wr_ctrl   = w_wr & (csr_address == 2'd0);
    assign w_start     = w_wr_ctrl & csr_writedata[0] & ~csr_writedata[4];
    assign w_abort     = w_wr_ctrl & csr_writedata[4];
    assign w_done_clr  = w_wr_ctrl & csr_writedata[8];
    assign w_busy      = (r_state != S_IDLE);
    // FIN is still "busy" for readback but is past the point where ABORT matters
    assign w_active    = (r_state == S_FILL) | (r_state == S_RD) | (r_state == S_CMP_LAST);
    // An abort in the same cycle drops the compare of the word in flight
    assign w_cmp_en    = r_cmp_vld & ((r_state == S_RD) | (r_state == S_CMP_LAST)) & ~w_abort;
    assign w_mismatch  = w_cmp_en & (mem_readdata != r_cmp_exp);
    assign w_range_cnt = csr_writedata[16 +: CNT_W];
    assign w_cnt_clamp = (w_range_cnt > DEPTH) ? DEPTH : w_range_cnt;
    assign w_unused    = &{1'b0, csr_writedata};

    assign irq            = r_done & r_irq_en;
    assign mem_address    = r_addr;
    assign mem_writedata  = r_data;
    assign mem_chipselect = (r_state == S_FILL) | (r_state == S_RD);
    assign mem_write      = (r_state == S_FILL);
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;
    assign csr_readdata   = r_rdata;

    // CSR configuration, operation sequencing, address/data stepping and read-back compare
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_mode        <= 1'b0;
            r_inc         <= 1'b0;
            r_irq_en      <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_aborted     <= 1'b0;
            r_abort_pend  <= 1'b0;
            r_start_addr  <= '0;
            r_count       <= '0;
            r_pattern     <= '0;
            r_addr        <= '0;
            r_data        <= '0;
            r_left        <= '0;
            r_cmp_vld     <= 1'b0;
            r_cmp_addr    <= '0;
            r_cmp_exp     <= '0;
            r_mis_cnt     <= '0;
            r_first_bad   <= '0;
            r_first_valid <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_irq_en <= csr_writedata[3];
            if (!w_busy) begin
                if (w_wr_ctrl) begin
                    r_mode <= csr_writedata[1];
                    r_inc  <= csr_writedata[2];
                end
                if (w_wr && csr_address == 2'd1) begin
                    r_start_addr <= csr_writedata[ADDR_W-1:0];
                    r_count      <= w_cnt_clamp;
                end
                if (w_wr && csr_address == 2'd2) r_pattern <= csr_writedata[DATA_W-1:0];
            end
            if (w_done_clr) r_done <= 1'b0;

            if (w_mismatch) begin
                r_mis_cnt <= r_mis_cnt + CNT_W'(1);
                if (!r_first_valid) begin
                    r_first_bad   <= r_cmp_addr;
                    r_first_valid <= 1'b1;
                end
            end

            if (w_active && w_abort) begin
                r_abort_pend <= 1'b1;
                r_cmp_vld    <= 1'b0;
                r_state      <= S_FIN;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_done        <= 1'b0;
                            r_err         <= 1'b0;
                            r_aborted     <= 1'b0;
                            r_abort_pend  <= 1'b0;
                            r_mis_cnt     <= '0;
                            r_first_bad   <= '0;
                            r_first_valid <= 1'b0;
                            r_cmp_vld     <= 1'b0;
                            r_addr        <= r_start_addr;
                            r_data        <= r_pattern;
                            r_left        <= r_count;
                            if (r_count == '0)         r_state <= S_FIN;
                            else if (csr_writedata[1]) r_state <= S_RD;
                            else                       r_state <= S_FILL;
                        end
                    end
                    S_FILL: begin
                        r_addr <= r_addr + ADDR_W'(1);
                        r_data <= r_data + DATA_W'(r_inc);
                        r_left <= r_left - CNT_W'(1);
                        if (r_left == CNT_W'(1)) r_state <= S_FIN;
                    end
                    S_RD: begin
                        r_cmp_vld  <= 1'b1;
                        r_cmp_addr <= r_addr;
                        r_cmp_exp  <= r_data;
                        r_addr     <= r_addr + ADDR_W'(1);
                        r_data     <= r_data + DATA_W'(r_inc);
                        r_left     <= r_left - CNT_W'(1);
                        if (r_left == CNT_W'(1)) r_state <= S_CMP_LAST;
                    end
                    S_CMP_LAST: begin
                        r_cmp_vld <= 1'b0;
                        r_state   <= S_FIN;
                    end
                    S_FIN: begin
                        r_done    <= 1'b1;
                        r_err     <= (r_mis_cnt != '0);
                        r_aborted <= r_abort_pend;
                        r_state   <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Registered CSR read mux, updated only on a qualified read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else if (csr_chipselect && csr_read) begin
            case (csr_address)
                2'd0: r_rdata <= {21'd0, r_aborted, r_err, r_done, 4'd0,
                                  r_irq_en, r_inc, r_mode, w_busy};
                2'd1: r_rdata <= (32'(r_count) << 16) | 32'(r_start_addr);
                2'd2: r_rdata <= 32'(r_pattern);
                default: r_rdata <= (32'(r_first_valid) << 31) | (32'(r_first_bad) << 16)
                                    | 32'(r_mis_cnt);
            endcase
        end
    end

endmodule

// File: tb/tb_nios_upc_mem_fill_check.sv
// Testbench for nios_upc_mem_fill_check: RAM model with write log, directed
// vector table, hand-written corner sequences and randomized fill/check runs.
module tb_nios_upc_mem_fill_check;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  csr_address;
    logic        csr_chipselect;
    logic        csr_write;
    logic        csr_read;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata;
    logic        irq;
    logic [9:0]  mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata;

    always #5 clk = ~clk;

    nios_upc_mem_fill_check #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .csr_address(csr_address), .csr_chipselect(csr_chipselect),
        .csr_write(csr_write), .csr_read(csr_read),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
        .irq(irq),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    // RAM model: 1-cycle read latency, logs every write with its cycle number
    typedef struct { logic [9:0] a; logic [31:0] d; int c; } wr_t;
    logic [31:0] ram [0:1023];
    wr_t         wr_q[$];
    int          cyc = 0;
    int          cs_count = 0;
    logic        bk_we = 1'b0;
    logic [9:0]  bk_addr = '0;
    logic [31:0] bk_data = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_chipselect) cs_count <= cs_count + 1;
        if (mem_chipselect && mem_write) begin
            ram[mem_address] <= mem_writedata;
            wr_q.push_back('{mem_address, mem_writedata, cyc});
        end else if (bk_we) begin
            ram[bk_addr] <= bk_data;
        end
        mem_readdata <= ram[mem_address];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge
    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        csr_address = a; csr_writedata = d; csr_chipselect = 1'b1; csr_write = 1'b1;
        @(negedge clk);
        csr_chipselect = 1'b0; csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        csr_address = a; csr_chipselect = 1'b1; csr_read = 1'b1;
        @(negedge clk);
        csr_chipselect = 1'b0; csr_read = 1'b0;
        d = csr_readdata;
    endtask

    task automatic bk_write(input logic [9:0] a, input logic [31:0] d);
        bk_addr = a; bk_data = d; bk_we = 1'b1;
        @(negedge clk);
        bk_we = 1'b0;
    endtask

    task automatic wait_irq(input int max, output int n);
        n = 0;
        while (irq !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    function automatic logic [31:0] ctrl_word(input bit busy, input bit mode, input bit inc,
                                              input bit irqen, input bit done, input bit err,
                                              input bit ab);
        return (32'(ab) << 10) | (32'(err) << 9) | (32'(done) << 8) | (32'(irqen) << 3)
             | (32'(inc) << 2) | (32'(mode) << 1) | 32'(busy);
    endfunction

    function automatic logic [9:0] word_addr(input logic [9:0] st, input int i);
        return 10'((int'(st) + i) % 1024);
    endfunction

    function automatic logic [31:0] word_data(input logic [31:0] pat, input bit inc, input int i);
        return inc ? pat + 32'(i) : pat;
    endfunction

    // Expected result of a check pass, computed from what the RAM model holds
    task automatic model_check(input logic [9:0] st, input int cnt, input logic [31:0] pat,
                               input bit inc, output int mis, output logic [9:0] first,
                               output bit fv);
        logic [9:0] a;
        mis = 0; first = '0; fv = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            a = word_addr(st, i);
            if (ram[a] !== word_data(pat, inc, i)) begin
                mis++;
                if (!fv) begin first = a; fv = 1'b1; end
            end
        end
    endtask

    task automatic verify_fill(input int base, input logic [9:0] st, input int cnt,
                               input logic [31:0] pat, input bit inc, input int c0);
        int bad;
        int got;
        wr_t w;
        bad = 0;
        got = wr_q.size() - base;
        chk("fill_count", got, cnt);
        for (int i = 0; i < got && i < cnt; i++) begin
            w = wr_q[base + i];
            if (w.a !== word_addr(st, i) || w.d !== word_data(pat, inc, i) || w.c != c0 + i)
                bad++;
        end
        chk("fill_log", bad, 0);
    endtask

    task automatic run_op(input logic [9:0] st, input int cnt, input logic [31:0] pat,
                          input bit mode, input bit inc, input int exp_mis,
                          input logic [9:0] exp_first, input bit exp_fv);
        int base, cs0, c0, n;
        logic [31:0] rd;
        csr_wr(2'd1, (32'(cnt) << 16) | 32'(st));
        csr_wr(2'd2, pat);
        base = wr_q.size();
        cs0  = cs_count;
        csr_wr(2'd0, 32'h9 | (32'(mode) << 1) | (32'(inc) << 2));
        c0 = cyc;
        wait_irq(3000, n);
        chk("latency", n, (cnt == 0) ? 1 : (mode ? cnt + 2 : cnt + 1));
        chk("mem_accesses", cs_count - cs0, cnt);
        if (mode) chk("check_no_write", wr_q.size() - base, 0);
        else      verify_fill(base, st, cnt, pat, inc, c0);
        csr_rd(2'd3, rd);
        chk("result", rd, {exp_fv, 5'd0, exp_first, 5'd0, 11'(exp_mis)});
        csr_rd(2'd0, rd);
        chk("ctrl_done", rd, ctrl_word(1'b0, mode, inc, 1'b1, 1'b1, exp_mis != 0, 1'b0));
    endtask

    typedef struct {
        logic [9:0]  st;
        int          cnt;
        logic [31:0] pat;
        bit          inc;
        bit          corrupt;
        logic [9:0]  bad;
        int          exp_mis;
        logic [9:0]  exp_first;
        bit          exp_fv;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [31:0] rd;
        logic [9:0]  st, a, first;
        logic [31:0] pat, pat2;
        int          cnt, n, mis, base, cs0, k;
        bit          inc, inc2, fv;

        vecs[0] = '{10'h3FE, 4, 32'hA5A50000, 1'b1, 1'b0, 10'h000, 0, 10'h000, 1'b0};
        vecs[1] = '{10'h3FE, 4, 32'hA5A50000, 1'b1, 1'b1, 10'h000, 1, 10'h000, 1'b1};
        vecs[2] = '{10'h100, 8, 32'hDEADBEEF, 1'b0, 1'b1, 10'h105, 1, 10'h105, 1'b1};
        vecs[3] = '{10'h3FF, 2, 32'hFFFFFFFF, 1'b1, 1'b0, 10'h000, 0, 10'h000, 1'b0};
        vecs[4] = '{10'h010, 1, 32'h00000001, 1'b0, 1'b1, 10'h010, 1, 10'h010, 1'b1};
        vecs[5] = '{10'h123, 0, 32'h0BADF00D, 1'b1, 1'b0, 10'h000, 0, 10'h000, 1'b0};

        reset_n = 1'b0;
        csr_address = '0; csr_chipselect = 1'b0; csr_write = 1'b0;
        csr_read = 1'b0; csr_writedata = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cs", mem_chipselect, 0);
        chk("rst_we", mem_write, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_wdata", mem_writedata, 0);
        chk("rst_irq", irq, 0);
        chk("rst_rdata", csr_readdata, 0);
        chk("byteenable", mem_byteenable, 4'hF);
        chk("clken", mem_clken, 1);
        reset_n = 1'b1;
        @(negedge clk);
        csr_rd(2'd0, rd);
        chk("rst_ctrl", rd, 0);

        // COUNT clamping and register readback
        csr_wr(2'd1, 32'h07FF_0005);
        csr_rd(2'd1, rd); chk("clamp_2047", rd, 32'h0400_0005);
        csr_wr(2'd1, 32'h0401_03FF);
        csr_rd(2'd1, rd); chk("clamp_1025", rd, 32'h0400_03FF);
        csr_wr(2'd1, 32'h0400_0000);
        csr_rd(2'd1, rd); chk("count_1024", rd, 32'h0400_0000);
        csr_wr(2'd2, 32'h13579BDF);
        csr_rd(2'd2, rd); chk("pattern_rb", rd, 32'h13579BDF);

        // Directed table: fill, optional corruption, check
        for (int v = 0; v < 6; v++) begin
            run_op(vecs[v].st, vecs[v].cnt, vecs[v].pat, 1'b0, vecs[v].inc, 0, 10'h0, 1'b0);
            if (vecs[v].corrupt) bk_write(vecs[v].bad, ram[vecs[v].bad] ^ 32'h1);
            run_op(vecs[v].st, vecs[v].cnt, vecs[v].pat, 1'b1, vecs[v].inc,
                   vecs[v].exp_mis, vecs[v].exp_first, vecs[v].exp_fv);
        end

        // COUNT = 0 and DONE-clear landing on FIN: FIN keeps DONE
        csr_wr(2'd1, 32'h0000_0000);
        cs0 = cs_count;
        csr_wr(2'd0, 32'h09);
        chk("cnt0_irq_early", irq, 0);
        csr_wr(2'd0, 32'h108);
        chk("fin_beats_clear", irq, 1);
        chk("cnt0_no_access", cs_count - cs0, 0);
        csr_rd(2'd0, rd); chk("fin_ctrl", rd, ctrl_word(0, 0, 0, 1, 1, 0, 0));
        csr_wr(2'd0, 32'h108);
        chk("done_clear_irq", irq, 0);

        // START together with ABORT while idle: nothing starts
        csr_wr(2'd1, 32'h0005_0000);
        cs0 = cs_count;
        csr_wr(2'd0, 32'h19);
        repeat (8) @(negedge clk);
        chk("start_abort_access", cs_count - cs0, 0);
        chk("start_abort_irq", irq, 0);
        csr_rd(2'd0, rd); chk("start_abort_ctrl", rd, ctrl_word(0, 0, 0, 1, 0, 0, 0));

        // Writes and START while busy are ignored; DONE clear drops irq
        csr_wr(2'd1, (32'd100 << 16) | 32'h020);
        csr_wr(2'd2, 32'h11110000);
        base = wr_q.size();
        csr_wr(2'd0, 32'h0D);
        csr_wr(2'd2, 32'h12345678);
        csr_wr(2'd1, 32'h0005_0300);
        csr_wr(2'd0, 32'h0B);
        csr_rd(2'd2, rd); chk("busy_pattern", rd, 32'h11110000);
        csr_rd(2'd1, rd); chk("busy_range", rd, (32'd100 << 16) | 32'h020);
        csr_rd(2'd0, rd); chk("busy_ctrl", rd, ctrl_word(1, 0, 1, 1, 0, 0, 0));
        wait_irq(3000, n);
        chk("busy_irq", irq, 1);
        verify_fill(base, 10'h020, 100, 32'h11110000, 1'b1, wr_q[base].c);
        csr_wr(2'd0, 32'h10C);
        chk("clear_irq", irq, 0);
        csr_rd(2'd0, rd); chk("clear_ctrl", rd, ctrl_word(0, 0, 1, 1, 0, 0, 0));

        // ABORT after 10 writes of a 1024-word fill
        csr_wr(2'd1, 32'h0400_0000);
        csr_wr(2'd2, 32'hCAFE0000);
        base = wr_q.size();
        csr_wr(2'd0, 32'h0D);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (wr_q.size() - base >= 10) break;
        end
        csr_wr(2'd0, 32'h18);
        wait_irq(100, n);
        repeat (4) @(negedge clk);
        n = wr_q.size() - base;
        chk("abort_writes", (n >= 10 && n <= 11), 1);
        csr_rd(2'd0, rd); chk("abort_ctrl", rd, ctrl_word(0, 0, 1, 1, 1, 0, 1));
        csr_rd(2'd3, rd); chk("abort_result", rd, 0);

        // Asynchronous reset in the middle of a fill
        csr_wr(2'd1, (32'd100 << 16) | 32'h155);
        csr_wr(2'd2, 32'hABCD0000);
        csr_rd(2'd2, rd); chk("pre_rst_rdata", rd, 32'hABCD0000);
        csr_wr(2'd0, 32'h0D);
        repeat (5) @(negedge clk);
        chk("pre_rst_cs", mem_chipselect, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_cs", mem_chipselect, 0);
        chk("arst_we", mem_write, 0);
        chk("arst_addr", mem_address, 0);
        chk("arst_wdata", mem_writedata, 0);
        chk("arst_rdata", csr_readdata, 0);
        chk("arst_irq", irq, 0);
        @(negedge clk);
        reset_n = 1'b1;
        cs0 = cs_count;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", cs_count - cs0, 0);
        csr_rd(2'd0, rd); chk("post_rst_ctrl", rd, 0);
        csr_rd(2'd2, rd); chk("post_rst_pattern", rd, 0);

        // Randomized fill / corrupt / check against the reference model
        for (int r = 0; r < 12; r++) begin
            st  = 10'($urandom_range(0, 1023));
            cnt = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1000, 1024))
                                              : int'($urandom_range(0, 40));
            pat = $urandom;
            inc = 1'($urandom_range(0, 1));
            run_op(st, cnt, pat, 1'b0, inc, 0, 10'h0, 1'b0);
            if (cnt > 0) begin
                k = $urandom_range(0, 3);
                for (int j = 0; j < k; j++) begin
                    a = word_addr(st, int'($urandom_range(0, cnt - 1)));
                    bk_write(a, ram[a] ^ (32'h1 << $urandom_range(0, 31)));
                end
            end
            pat2 = pat;
            inc2 = inc;
            if ($urandom_range(0, 3) == 0) begin
                pat2 = pat + 32'd1;
                inc2 = 1'($urandom_range(0, 1));
            end
            model_check(st, cnt, pat2, inc2, mis, first, fv);
            run_op(st, cnt, pat2, 1'b1, inc2, mis, first, fv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
